univ_shift_reg: RTL and testbench



---
 rtl/univ_shift_reg_pkg.sv | 25 ++
 rtl/univ_shift_reg_if.sv | 29 ++
 rtl/univ_shift_reg_counter.sv | 60 ++++++
 rtl/univ_shift_reg.sv | 58 +++++
 tb/tb_univ_shift_reg.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encoding,
// shift direction type and small decode helpers.
package univ_shift_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD = 2'b00;
  localparam mode_t MODE_SHR  = 2'b01;
  localparam mode_t MODE_SHL  = 2'b10;
  localparam mode_t MODE_LOAD = 2'b11;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_t;

  function automatic logic is_shift_mode(input mode_t m);
    return (m == MODE_SHR) || (m == MODE_SHL);
  endfunction

  function automatic dir_t mode_dir(input mode_t m);
    return (m == MODE_SHL) ? DIR_LEFT : DIR_RIGHT;
  endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle of the universal shift register. The master side drives
// the operation, the slave side (the register) returns contents and status.
interface univ_shift_reg_if #(
  parameter int WIDTH = 8
);
  import univ_shift_pkg::*;

  logic             en;
  logic             clr;
  mode_t            mode;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] parallel_in;
  logic [WIDTH-1:0] parallel_out;
  logic             sout_r;
  logic             sout_l;
  logic             word_done;

  modport master (
    output en, clr, mode, sin_r, sin_l, parallel_in,
    input  parallel_out, sout_r, sout_l, word_done
  );

  modport slave (
    input  en, clr, mode, sin_r, sin_l, parallel_in,
    output parallel_out, sout_r, sout_l, word_done
  );

endinterface

// File: rtl/univ_shift_reg_counter.sv
// Counts consecutive same-direction shifts and raises a one-cycle word_done
// when a full WIDTH-bit word has entered the register.
module shift_word_counter
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic shift_valid,
  input  dir_t shift_dir,
  input  logic load,
  output logic word_done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] r_cnt;
  dir_t          r_last_dir;
  logic          r_word_done;

  logic w_same_dir;
  logic w_wrap;

  assign w_same_dir = (shift_dir == r_last_dir);
  assign w_wrap     = w_same_dir && (r_cnt == CNT_MAX);

  // last_dir survives clr and load; only rst returns it to right.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_last_dir  <= DIR_RIGHT;
      r_word_done <= 1'b0;
    end else if (clr || load) begin
      r_cnt       <= '0;
      r_word_done <= 1'b0;
    end else if (shift_valid) begin
      r_last_dir <= shift_dir;
      if (!w_same_dir) begin
        // A direction change starts a new word with this shift as bit one.
        r_cnt       <= CNT_ONE;
        r_word_done <= 1'b0;
      end else if (w_wrap) begin
        r_cnt       <= '0;
        r_word_done <= 1'b1;
      end else begin
        r_cnt       <= r_cnt + CNT_ONE;
        r_word_done <= 1'b0;
      end
    end else begin
      r_word_done <= 1'b0;
    end
  end

  assign word_done = r_word_done;

endmodule

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: hold, shift right, shift left and
// parallel load, with a word-completion pulse from shift_word_counter.
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  univ_shift_reg_if.slave       bus
);

  logic [WIDTH-1:0] r_q;

  logic w_shift_valid;
  logic w_load;
  dir_t w_shift_dir;
  logic w_word_done;

  // en=0 masks every operation so the counter sees neither shift nor load.
  assign w_shift_valid = bus.en && is_shift_mode(bus.mode);
  assign w_load        = bus.en && (bus.mode == MODE_LOAD);
  assign w_shift_dir   = mode_dir(bus.mode);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (bus.clr) begin
      r_q <= '0;
    end else if (bus.en) begin
      case (bus.mode)
        MODE_HOLD: r_q <= r_q;
        MODE_SHR:  r_q <= {bus.sin_r, r_q[WIDTH-1:1]};
        MODE_SHL:  r_q <= {r_q[WIDTH-2:0], bus.sin_l};
        MODE_LOAD: r_q <= bus.parallel_in;
        default:   r_q <= r_q;
      endcase
    end
  end

  shift_word_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk         (clk),
    .rst         (rst),
    .clr         (bus.clr),
    .shift_valid (w_shift_valid),
    .shift_dir   (w_shift_dir),
    .load        (w_load),
    .word_done   (w_word_done)
  );

  assign bus.parallel_out = r_q;
  assign bus.sout_r       = r_q[0];
  assign bus.sout_l       = r_q[WIDTH-1];
  assign bus.word_done    = w_word_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg at WIDTH=4: the driver pushes model
// predictions, an independent monitor pops and compares after each edge.
module tb_univ_shift_reg;
  import univ_shift_pkg::*;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] q;
    logic         wd;
    int           id;
  } exp_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   pushed   = 0;
  int   popped   = 0;
  exp_t exp_q[$];

  // Reference model: run length of consecutive same-direction shifts.
  int   m_q;
  int   m_run;
  int   m_dir;
  logic m_wd;

  univ_shift_reg_if #(.WIDTH(W)) bus ();

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_q = 0; m_run = 0; m_dir = 0; m_wd = 1'b0;
  endtask

  task automatic model_step(input logic r, e, c, input logic [1:0] m,
                            input logic sr, sl, input logic [W-1:0] p);
    int d;
    if (r) begin
      model_reset();
    end else if (c) begin
      m_q = 0; m_run = 0; m_wd = 1'b0;
    end else if (!e || m == 2'b00) begin
      m_wd = 1'b0;
    end else if (m == 2'b11) begin
      m_q = int'(p); m_run = 0; m_wd = 1'b0;
    end else begin
      d = (m == 2'b10) ? 1 : 0;
      if (d == 0) m_q = (m_q / 2) + (sr ? (1 << (W - 1)) : 0);
      else        m_q = ((m_q * 2) % (1 << W)) + (sl ? 1 : 0);
      m_run = (d == m_dir) ? m_run + 1 : 1;
      m_dir = d;
      m_wd  = ((m_run % W) == 0);
    end
  endtask

  task automatic do_cycle(input logic r, e, c, input logic [1:0] m,
                          input logic sr, sl, input logic [W-1:0] p);
    exp_t x;
    @(negedge clk);
    rst             = r;
    bus.en          = e;
    bus.clr         = c;
    bus.mode        = m;
    bus.sin_r       = sr;
    bus.sin_l       = sl;
    bus.parallel_in = p;
    model_step(r, e, c, m, sr, sl, p);
    x.q  = W'(m_q);
    x.wd = m_wd;
    x.id = pushed;
    pushed++;
    exp_q.push_back(x);
  endtask

  task automatic check_now(input string name, input logic [W-1:0] got_q,
                           input logic got_wd, input logic [W-1:0] want_q);
    checks++;
    if (got_q !== want_q || got_wd !== 1'b0) begin
      failures++;
      $display("FAIL %s got q=%b wd=%b want q=%b wd=0", name, got_q, got_wd, want_q);
    end
  endtask

  // Monitor: one line per transaction, compared against the queued prediction.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        popped++;
        checks++;
        if (bus.parallel_out !== x.q || bus.word_done !== x.wd) begin
          failures++;
          $display("FAIL txn%0d q/wd got q=%b wd=%b want q=%b wd=%b",
                   x.id, bus.parallel_out, bus.word_done, x.q, x.wd);
        end else begin
          $display("txn%0d q=%b wd=%b ok", x.id, bus.parallel_out, bus.word_done);
        end
        checks++;
        if (bus.sout_r !== x.q[0] || bus.sout_l !== x.q[W-1]) begin
          failures++;
          $display("FAIL txn%0d sout got r=%b l=%b want r=%b l=%b",
                   x.id, bus.sout_r, bus.sout_l, x.q[0], x.q[W-1]);
        end
      end
    end
  end

  initial begin
    int   pref;
    int   r;
    logic e, c, sr, sl;
    logic [1:0] m;
    rst = 1'b0;
    bus.en = 1'b0; bus.clr = 1'b0; bus.mode = MODE_HOLD;
    bus.sin_r = 1'b0; bus.sin_l = 1'b0; bus.parallel_in = '0;
    model_reset();
    #1 rst = 1'b1;
    #1 check_now("reset_async", bus.parallel_out, bus.word_done, 4'b0000);

    // Reset overrides a pending load; load takes effect once released.
    do_cycle(1, 1, 0, MODE_LOAD, 0, 0, 4'b1111);
    do_cycle(1, 1, 0, MODE_LOAD, 0, 0, 4'b1111);
    do_cycle(0, 1, 0, MODE_LOAD, 0, 0, 4'b1111);

    // Right shifts 1,0,1,1 from zero.
    do_cycle(0, 1, 0, MODE_LOAD, 0, 0, 4'b0000);
    do_cycle(0, 1, 0, MODE_SHR, 1, 0, 4'b0000);
    do_cycle(0, 1, 0, MODE_SHR, 0, 0, 4'b0000);
    do_cycle(0, 1, 0, MODE_SHR, 1, 0, 4'b0000);
    do_cycle(0, 1, 0, MODE_SHR, 1, 0, 4'b0000);

    // Left shift after load, then disabled load must hold.
    do_cycle(0, 1, 0, MODE_LOAD, 0, 0, 4'b1011);
    do_cycle(0, 1, 0, MODE_SHL, 0, 0, 4'b0000);
    do_cycle(0, 0, 0, MODE_LOAD, 0, 0, 4'b0000);

    // Direction change restarts the word.
    do_cycle(0, 1, 0, MODE_LOAD, 0, 0, 4'b0101);
    repeat (2) do_cycle(0, 1, 0, MODE_SHR, 1, 0, 4'b0000);
    repeat (4) do_cycle(0, 1, 0, MODE_SHL, 0, 1, 4'b0000);

    // Shifts with hold gaps.
    do_cycle(0, 1, 0, MODE_LOAD, 0, 0, 4'b0000);
    do_cycle(0, 1, 0, MODE_SHR, 1, 0, 4'b0000);
    do_cycle(0, 1, 0, MODE_HOLD, 0, 0, 4'b0000);
    do_cycle(0, 1, 0, MODE_SHR, 0, 0, 4'b0000);
    do_cycle(0, 1, 0, MODE_HOLD, 0, 0, 4'b0000);
    do_cycle(0, 1, 0, MODE_SHR, 1, 0, 4'b0000);
    do_cycle(0, 1, 0, MODE_HOLD, 0, 0, 4'b0000);
    do_cycle(0, 1, 0, MODE_SHR, 1, 0, 4'b0000);

    // Asynchronous reset mid-word, between edges.
    do_cycle(0, 1, 0, MODE_LOAD, 0, 0, 4'b0110);
    repeat (3) do_cycle(0, 1, 0, MODE_SHR, 1, 0, 4'b0000);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_now("reset_midword", bus.parallel_out, bus.word_done, 4'b0000);
    model_reset();
    do_cycle(1, 1, 0, MODE_SHR, 1, 0, 4'b0000);
    repeat (4) do_cycle(0, 1, 0, MODE_SHR, 1, 0, 4'b0000);

    // clr wins over en=0.
    do_cycle(0, 1, 0, MODE_LOAD, 0, 0, 4'b1001);
    do_cycle(0, 0, 1, MODE_LOAD, 0, 0, 4'b1111);

    // Randomised phase with a sticky preferred direction so words complete.
    pref = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) pref = 3 - pref;
      r  = int'($urandom_range(0, 19));
      e  = ($urandom_range(0, 9) != 0);
      c  = ($urandom_range(0, 39) == 0);
      sr = 1'($urandom);
      sl = 1'($urandom);
      if (r == 0)      m = MODE_HOLD;
      else if (r == 1) m = MODE_LOAD;
      else if (r < 4)  m = 2'(3 - pref);
      else             m = 2'(pref);
      do_cycle(0, e, c, m, sr, sl, 4'($urandom));
    end

    do_cycle(0, 0, 0, MODE_HOLD, 0, 0, 4'b0000);
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0 || popped != pushed) begin
      failures++;
      $display("FAIL drain got popped=%0d want %0d", popped, pushed);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
